// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   state_e : FSM states (MUL2 is only entered when MULT_ARB_OPREG_EN is defined)
//   OP_W    : operand width of the shared multiplier
//   PROD_W  : product width returned by the shared multiplier
package mult_share_arbiter_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    MUL2 = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection (purely combinational).
//   req : request vector, one bit per requester
//   ptr : highest-priority index for this decision
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester (zero when no request)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     idx
);

  int unsigned w_c;
  logic        w_found;

  // Scan circularly from ptr; the first requester found wins.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    w_found = 1'b0;
    w_c     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_c = (int'(ptr) + i) % NUM_REQ;
      if (!w_found && req[w_c]) begin
        w_found  = 1'b1;
        gnt[w_c] = 1'b1;
        idx      = IDW'(w_c);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external combinational 8x8 signed multiplier among NUM_REQ requesters.
// A requester is granted round-robin in IDLE, its operands are captured and driven to
// the multiplier, the product is registered and returned with the requester index.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_ready       : per-requester operand handshake (ready is one-hot or zero)
//   req_a, req_b              : packed signed operands, requester k at [8k+7:8k]
//   mult_a, mult_b            : operands to the shared multiplier
//   mult_product              : product from the shared multiplier
//   resp_valid/resp_ready     : result handshake
//   resp_id, resp_product     : owner index and signed product
// Build option: define MULT_ARB_OPREG_EN to add a MUL2 state, giving the multiplier a
// two-cycle path (grant to resp_valid latency 3 instead of 2).
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [OP_W-1:0]        mult_a,
  output logic [OP_W-1:0]        mult_b,
  input  logic [PROD_W-1:0]      mult_product,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [PROD_W-1:0]      resp_product
);

  state_e              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_id;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [PROD_W-1:0]   r_prod;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IDW-1:0]      w_idx;
  logic [IDW-1:0]      w_ptr_nxt;
  logic                w_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx)
  );

  assign w_grant   = (r_state == IDLE) && (|req_valid);
  assign w_ptr_nxt = (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  assign req_ready    = (r_state == IDLE) ? w_gnt : '0;
  assign mult_a       = r_a;
  assign mult_b       = r_b;
  assign resp_valid   = (r_state == RESP);
  assign resp_id      = r_id;
  assign resp_product = r_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_prod  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_id    <= w_idx;
            r_a     <= req_a[int'(w_idx)*OP_W +: OP_W];
            r_b     <= req_b[int'(w_idx)*OP_W +: OP_W];
            r_state <= MUL;
          end
        end
`ifdef MULT_ARB_OPREG_EN
        // Operands have had a full cycle to propagate; sample in MUL2.
        MUL: r_state <= MUL2;
        MUL2: begin
          r_prod  <= mult_product;
          r_state <= RESP;
        end
`else
        MUL: begin
          r_prod  <= mult_product;
          r_state <= RESP;
        end
        MUL2: r_state <= IDLE;
`endif
        RESP: begin
          // Return to IDLE only; the next grant is issued there, never in this cycle.
          if (resp_ready) begin
            r_ptr   <= w_ptr_nxt;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

`ifdef MULT_ARB_OPREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic [15:0] mult_product;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_product;

  // Behavioural model of the external shared multiplier.
  logic signed [15:0] sa, sb;
  assign sa = $signed(mult_a);
  assign sb = $signed(mult_b);
  assign mult_product = sa * sb;

  mult_share_arbiter #(.NUM_REQ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (mult_product),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int          k;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Called with inputs applied; returns with the grant cycle sampled.
  task automatic wait_grant(input logic [3:0] exp, output int waited);
    waited = 0;
    while (req_ready === 4'b0 && waited < 8) begin
      tick();
      waited++;
    end
    chk("grant", 32'(req_ready), 32'(exp));
  endtask

  // Called in the MUL cycle; returns in the first resp_valid cycle.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 12) begin
      chk("ready_low_busy", 32'(req_ready), 32'h0);
      tick();
      lat++;
    end
    chk("ready_low_resp", 32'(req_ready), 32'h0);
  endtask

  initial begin
    int lat;
    int w;
    vecs[0] = '{0, 8'sd7,    -8'sd3,   16'hFFEB};
    vecs[1] = '{1, -8'sd128, -8'sd128, 16'h4000};
    vecs[2] = '{2, -8'sd128, 8'sd127,  16'hC080};
    vecs[3] = '{3, 8'sd0,    -8'sd5,   16'h0000};
    vecs[4] = '{1, 8'sd127,  8'sd127,  16'h3F01};
    vecs[5] = '{2, -8'sd1,   8'sd1,    16'hFFFF};

    req_a = '0;
    req_b = '0;
    rst   = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_resp_product", 32'(resp_product), 32'h0);
    chk("rst_mult_a", 32'(mult_a), 32'h0);
    chk("rst_mult_b", 32'(mult_b), 32'h0);
    do_reset();

    // Single-requester vectors.
    for (int i = 0; i < 6; i++) begin
      req_a = '0;
      req_b = '0;
      req_a[8*vecs[i].k +: 8] = vecs[i].a;
      req_b[8*vecs[i].k +: 8] = vecs[i].b;
      req_valid = 4'b1 << vecs[i].k;
      #1;
      wait_grant(4'b1 << vecs[i].k, w);
      tick();
      chk("ready_one_cycle", 32'(req_ready), 32'h0);
      chk("mult_a", 32'(mult_a), 32'(vecs[i].a));
      chk("mult_b", 32'(mult_b), 32'(vecs[i].b));
      req_valid = '0;
      wait_resp(lat);
      chk("latency", 32'(lat), 32'(LAT));
      chk("product", 32'(resp_product), 32'(vecs[i].p));
      chk("resp_id", 32'(resp_id), 32'(vecs[i].k));
      tick();
    end

    // Round robin with all four requesters valid continuously.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_a[8*k +: 8] = 8'(k + 2);
      req_b[8*k +: 8] = 8'(-(k + 1));
    end
    req_valid = 4'hF;
    #1;
    for (int j = 0; j < 5; j++) begin
      logic [15:0] exp_p;
      case (j % 4)
        0: exp_p = 16'hFFFE;
        1: exp_p = 16'hFFFA;
        2: exp_p = 16'hFFF4;
        default: exp_p = 16'hFFEC;
      endcase
      wait_grant(4'b1 << (j % 4), w);
      if (j > 0) chk("rr_back_to_back", 32'(w), 32'h0);
      tick();
      chk("rr_ready_one_cycle", 32'(req_ready), 32'h0);
      wait_resp(lat);
      chk("rr_latency", 32'(lat), 32'(LAT));
      chk("rr_resp_id", 32'(resp_id), 32'(j % 4));
      chk("rr_product", 32'(resp_product), 32'(exp_p));
      tick();
    end

    // Backpressure: hold the response while other requesters wait.
    do_reset();
    req_a[15:8] = 8'sd5;
    req_b[15:8] = 8'sd6;
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    #1;
    wait_grant(4'b0010, w);
    tick();
    req_valid = 4'hF;
    wait_resp(lat);
    chk("bp_product", 32'(resp_product), 32'h1E);
    chk("bp_resp_id", 32'(resp_id), 32'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_valid_held", 32'(resp_valid), 32'h1);
      chk("bp_product_held", 32'(resp_product), 32'h1E);
      chk("bp_id_held", 32'(resp_id), 32'h1);
      chk("bp_no_grant", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_no_grant_handshake", 32'(req_ready), 32'h0);
    tick();
    chk("bp_next_grant_ptr", 32'(req_ready), 32'h4);

    // Reset asserted while in MUL.
    do_reset();
    req_a[23:16] = 8'sd3;
    req_b[23:16] = 8'sd3;
    req_valid = 4'b0100;
    #1;
    wait_grant(4'b0100, w);
    tick();
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("midrst_mult_a", 32'(mult_a), 32'h0);
    chk("midrst_resp_id", 32'(resp_id), 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      chk("midrst_no_resp", 32'(resp_valid), 32'h0);
    end
    req_valid = 4'hF;
    #1;
    wait_grant(4'b0001, w);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters sharing one 8x8 signed multiplier (legal range 2..8).
REQ-002 Parameter: IDW, default $clog2(NUM_REQ), requester-ID width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req_valid  input  NUM_REQ  per-requester operand valid.
REQ-006 Port: req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
REQ-007 Port: req_a  input  8*NUM_REQ  signed multiplicands, requester k at bits [8k+7:8k].
REQ-008 Port: req_b  input  8*NUM_REQ  signed multipliers, same packing.
REQ-009 Port: mult_a, mult_b  output  8 each  operands driven to the shared combinational multiplier.
REQ-010 Port: mult_product  input  16  signed product returned by the shared multiplier.
REQ-011 Port: resp_valid  output  1  result available.
REQ-012 Port: resp_ready  input  1  consumer accepts result.
REQ-013 Port: resp_id  output  IDW  requester index owning the result.
REQ-014 Port: resp_product  output  16  signed two's-complement product.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, RESP (plus MUL2 when MULT_ARB_OPREG_EN is defined).
REQ-016 IDLE: if any req_valid is set, the block SHALL grant exactly one requester by round-robin starting at pointer rr_ptr, assert that requester's req_ready for exactly that cycle, capture its req_a/req_b and index, and go to MUL; otherwise stay in IDLE with req_ready=0.
REQ-017 req_ready SHALL be zero in every state except the IDLE grant cycle.
REQ-018 mult_a/mult_b SHALL be driven from the captured operand registers, stable from MUL through RESP.
REQ-019 MUL: the block SHALL register mult_product into resp_product and go to RESP; result latency from grant = 2 cycles (3 with MULT_ARB_OPREG_EN).
REQ-020 RESP: resp_valid=1; resp_product and resp_id SHALL be held stable while resp_ready=0; on resp_valid&&resp_ready the block SHALL go to IDLE and set rr_ptr = granted index + 1 modulo NUM_REQ.
REQ-021 A new grant SHALL NOT be issued in the same cycle as a response handshake; peak throughput = one product per 3 cycles.
REQ-022 Round-robin wrap: when granted index = NUM_REQ-1, rr_ptr SHALL become 0.
REQ-023 Simultaneous requests: the lowest index at or above rr_ptr (circularly) SHALL win; no requester shall wait more than NUM_REQ-1 grants once valid.
REQ-024 A requester SHALL NOT need to hold req_valid after its grant; deasserting req_valid outside the grant cycle SHALL have no effect.
REQ-025 resp_product SHALL equal the exact signed product; full range is -16256..+16384 (-128*-128 = 0x4000).

Reset
REQ-026 On rst=1 (asynchronous), state SHALL be IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_product=0, mult_a=0, mult_b=0.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight request with no response; first grant after reset release SHALL favour requester 0.

Configuration
REQ-028 Macro MULT_ARB_OPREG_EN: when defined, a MUL2 state SHALL be inserted between MUL and RESP, with mult_product registered in MUL2, giving the multiplier a two-cycle path (grant-to-resp_valid latency 3); when undefined, MUL registers directly (latency 2).

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, MUL, MUL2, RESP), operand width 8 and product width 16 constants.
REQ-030 The round-robin grant logic SHALL be a separate sub-module rr_arbiter (inputs request vector, pointer; output one-hot grant and index); the multiplier stays outside the block.

Verification
REQ-031 Single request: req_valid=0001, a=7, b=-3 -> req_ready=0001 for 1 cycle, resp_valid 2 cycles later, resp_product=0xFFEB (-21), resp_id=0.
REQ-032 Extreme operands: a=-128, b=-128 -> 0x4000; a=-128, b=127 -> 0xC080; a=0, b=-5 -> 0x0000.
REQ-033 All four valid continuously from reset -> grant order 0,1,2,3,0 with rr_ptr wrap; each resp_id matches grant.
REQ-034 Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_product/resp_id stable, no req_ready asserted until handshake.
REQ-035 Reset mid-MUL: rst pulsed while in MUL -> resp_valid never asserts for that request; next grant goes to requester 0.
REQ-036 Repeat REQ-031 and REQ-033 with MULT_ARB_OPREG_EN defined -> identical results, latency 3.
